// File: rtl/blood_sprite_renderer_pkg.sv
// Shared constants and state encoding for the blood-splatter sprite renderer.
package sprite_pkg;
  localparam int SPR_SIZE = 64;
  localparam int COLOR_W  = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam logic [COLOR_W-1:0] TRANSPARENT_COLOR = 12'h000;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;
endpackage

// File: rtl/blood_sprite_renderer_if.sv
// Video, trigger, sprite-ROM and keyed-pixel signals of the renderer.
interface blood_sprite_renderer_if;
  import sprite_pkg::*;

  logic               video_on;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               frame_tick;
  logic               hit;
  logic [9:0]         hit_x;
  logic [9:0]         hit_y;
  logic [5:0]         rom_row;
  logic [5:0]         rom_col;
  logic [COLOR_W-1:0] rom_color;
  logic [COLOR_W-1:0] rgb_out;
  logic               sprite_on;
  logic               busy;

  modport master (
    output video_on, pixel_x, pixel_y, frame_tick, hit, hit_x, hit_y, rom_color,
    input  rom_row, rom_col, rgb_out, sprite_on, busy
  );

  modport slave (
    input  video_on, pixel_x, pixel_y, frame_tick, hit, hit_x, hit_y, rom_color,
    output rom_row, rom_col, rgb_out, sprite_on, busy
  );
endinterface

// File: rtl/blood_sprite_renderer_anim_ctrl.sv
// Pending-hit latch, IDLE/SHOW state machine and per-frame visibility counter.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int SHOW_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       show,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       busy
);
  localparam logic [7:0] SHOW_LOAD = 8'(SHOW_FRAMES);

  state_t     state_reg, state_next;
  logic       pend_valid_reg, pend_valid_next;
  logic [9:0] pend_x_reg, pend_x_next;
  logic [9:0] pend_y_reg, pend_y_next;
  logic [9:0] pos_x_reg, pos_x_next;
  logic [9:0] pos_y_reg, pos_y_next;
  logic [7:0] frames_left_reg, frames_left_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pend_valid_reg  <= 1'b0;
      pend_x_reg      <= '0;
      pend_y_reg      <= '0;
      pos_x_reg       <= '0;
      pos_y_reg       <= '0;
      frames_left_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pend_valid_reg  <= pend_valid_next;
      pend_x_reg      <= pend_x_next;
      pend_y_reg      <= pend_y_next;
      pos_x_reg       <= pos_x_next;
      pos_y_reg       <= pos_y_next;
      frames_left_reg <= frames_left_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pend_valid_next  = pend_valid_reg;
    pend_x_next      = pend_x_reg;
    pend_y_next      = pend_y_reg;
    pos_x_next       = pos_x_reg;
    pos_y_next       = pos_y_reg;
    frames_left_next = frames_left_reg;

    if (frame_tick) begin
      if (pend_valid_reg) begin
        pos_x_next       = pend_x_reg;
        pos_y_next       = pend_y_reg;
        frames_left_next = SHOW_LOAD;
        state_next       = SHOW;
        pend_valid_next  = 1'b0;
      end else if (state_reg == SHOW && frames_left_reg == 8'd1) begin
        state_next       = IDLE;
        frames_left_next = '0;
      end else if (state_reg == SHOW) begin
        frames_left_next = frames_left_reg - 8'd1;
      end
    end

    // A hit in the tick cycle stays pending for the following tick.
    if (hit) begin
      pend_valid_next = 1'b1;
      pend_x_next     = hit_x;
      pend_y_next     = hit_y;
    end
  end

  assign show  = (state_reg == SHOW);
  assign pos_x = pos_x_reg;
  assign pos_y = pos_y_reg;
  assign busy  = (state_reg == SHOW) || pend_valid_reg;
endmodule

// File: rtl/blood_sprite_renderer.sv
// Blood-splatter sprite reader: region test, ROM addressing and a two-stage
// keying pipeline matched to the external sprite ROM's one-cycle read latency.
module blood_sprite_renderer
  import sprite_pkg::*;
#(
  parameter int                 SHOW_FRAMES = 30,
  parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_COLOR
) (
  input  logic                    clk,
  input  logic                    reset_n,
  blood_sprite_renderer_if.slave  bus
);
  logic               show;
  logic [9:0]         pos_x, pos_y;
  logic [10:0]        dx, dy;
  logic               in_region;
  logic               in_region_d_reg;
  logic               opaque;
  logic [COLOR_W-1:0] keyed_rgb;
  logic               sprite_on_reg;
  logic [COLOR_W-1:0] rgb_reg;

  sprite_anim_ctrl #(
    .SHOW_FRAMES (SHOW_FRAMES)
  ) u_anim_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (bus.frame_tick),
    .hit        (bus.hit),
    .hit_x      (bus.hit_x),
    .hit_y      (bus.hit_y),
    .show       (show),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (bus.busy)
  );

  // Unsigned 11-bit difference: a set MSB means the pixel lies left of/above
  // the sprite, so edge sprites are clipped instead of wrapping.
  assign dx = {1'b0, bus.pixel_x} - {1'b0, pos_x};
  assign dy = {1'b0, bus.pixel_y} - {1'b0, pos_y};

  assign in_region = show && bus.video_on
                  && !dx[10] && (dx < 11'(SPR_SIZE))
                  && !dy[10] && (dy < 11'(SPR_SIZE));

  assign bus.rom_col = in_region ? dx[5:0] : 6'd0;
  assign bus.rom_row = in_region ? dy[5:0] : 6'd0;

  assign opaque = in_region_d_reg && (bus.rom_color != TRANSPARENT);

  generate
    for (genvar gi = 0; gi < COLOR_W; gi++) begin : g_key
      assign keyed_rgb[gi] = opaque & bus.rom_color[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_region_d_reg <= 1'b0;
      sprite_on_reg   <= 1'b0;
      rgb_reg         <= '0;
    end else begin
      in_region_d_reg <= in_region;
      sprite_on_reg   <= opaque;
      rgb_reg         <= keyed_rgb;
    end
  end

  assign bus.sprite_on = sprite_on_reg;
  assign bus.rgb_out   = rgb_reg;
endmodule
